// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller: state encoding,
// digit width and the anode one-hot decode helper.
package display_scan_ctrl_pkg;

    localparam int DIG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    // One bit of onehot(idx): true when this anode position is the selected digit.
    function automatic logic onehot_bit(input logic [2:0] idx, input logic [2:0] pos);
        return idx == pos;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_timer.sv
// Slot cycle counter: counts 0..limit, flags terminal count and restarts
// from 0 after it. A clear forces it back to 0 (used while idle/disabled).
module scan_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == limit);

    // Next count: clear wins, terminal count restarts the slot, else increment.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tc) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display sharing one BCD decoder. Data is double-buffered and committed
// only at frame boundaries (or when scanning starts).
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SHOW_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      habilitar,
    input  logic                      cargar,
    input  logic [DIG_W*N_DIGITS-1:0] datos,
    input  logic                      supr_ceros,
    output logic [DIG_W-1:0]          codigo,
    output logic [N_DIGITS-1:0]       anodos,
    output logic                      pendiente,
    output logic                      trama_fin
);

    localparam int WORD_W  = DIG_W * N_DIGITS;
    localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] SHOW_LIM  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   shadow_q, shadow_d;
    logic [WORD_W-1:0]   committed_q, committed_d;
    logic                pend_q, pend_d;
    logic                tf_q, tf_d;
    logic [N_DIGITS-1:0] anodos_q, anodos_d;
    logic [DIG_W-1:0]    codigo_q, codigo_d;
    logic                commit;
    logic                timer_clr;
    logic [CNT_W-1:0]    timer_lim;
    logic                timer_tc;
    logic [N_DIGITS-1:0] dig_en;
    logic [DIG_W-1:0]    dig_c [N_DIGITS];

    assign timer_clr = (state_q == IDLE) || !habilitar;
    assign timer_lim = (state_q == SHOW) ? SHOW_LIM : BLANK_LIM;

    scan_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (timer_clr),
        .limit(timer_lim),
        .tc   (timer_tc)
    );

    // Scan sequencing: IDLE -> SHOW -> BLANK -> SHOW(next digit) ...; disable always wins.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tf_d    = 1'b0;
        commit  = 1'b0;
        if (!habilitar) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    idx_d   = '0;
                    commit  = 1'b1;
                end
                SHOW: begin
                    if (timer_tc) begin
                        state_d = BLANK;
                    end
                end
                BLANK: begin
                    if (timer_tc) begin
                        state_d = SHOW;
                        if (idx_q == LAST_IDX) begin
                            idx_d  = '0;
                            tf_d   = 1'b1;
                            commit = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Double buffer: loads go to shadow; a load on a commit edge bypasses straight to committed.
    always_comb begin
        shadow_d    = shadow_q;
        committed_d = committed_q;
        pend_d      = pend_q;
        if (cargar && commit) begin
            shadow_d    = datos;
            committed_d = datos;
            pend_d      = 1'b0;
        end else begin
            if (commit && pend_q) begin
                committed_d = shadow_q;
                pend_d      = 1'b0;
            end
            if (cargar) begin
                shadow_d = datos;
                pend_d   = 1'b1;
            end
        end
    end

    // Per-digit view of the word that will be on display next cycle.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_dig
        assign dig_c[gi] = committed_d[gi*DIG_W +: DIG_W];
    end

    // Anode enable per digit, dark when it and every more significant digit are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        dig_en   = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run  = zero_run && (dig_c[i] == '0);
            dig_en[i] = onehot_bit(3'(idx_d), 3'(i)) && !((i != 0) && supr_ceros && zero_run);
        end
    end

    // Registered outputs follow the next state; codigo holds outside SHOW.
    always_comb begin
        anodos_d = '0;
        codigo_d = codigo_q;
        if (state_d == SHOW) begin
            anodos_d = dig_en;
            codigo_d = dig_c[idx_d];
        end
    end

    // State, data and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            committed_q <= '0;
            pend_q      <= 1'b0;
            tf_q        <= 1'b0;
            anodos_q    <= '0;
            codigo_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            committed_q <= committed_d;
            pend_q      <= pend_d;
            tf_q        <= tf_d;
            anodos_q    <= anodos_d;
            codigo_q    <= codigo_d;
        end
    end

    assign codigo    = codigo_q;
    assign anodos    = anodos_q;
    assign pendiente = pend_q;
    assign trama_fin = tf_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with N_DIGITS=4, SHOW_CYC=4,
// BLANK_CYC=2 (24-cycle frames).
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        habilitar;
    logic        cargar;
    logic [15:0] datos;
    logic        supr_ceros;
    logic [3:0]  codigo;
    logic [3:0]  anodos;
    logic        pendiente;
    logic        trama_fin;

    int total = 0;
    int bad   = 0;

    logic [3:0] an_obs [24];
    logic [3:0] cd_obs [24];
    logic       tf_obs [24];
    logic       pd_obs [24];

    display_scan_ctrl #(
        .N_DIGITS (4),
        .SHOW_CYC (4),
        .BLANK_CYC(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .habilitar (habilitar),
        .cargar    (cargar),
        .datos     (datos),
        .supr_ceros(supr_ceros),
        .codigo    (codigo),
        .anodos    (anodos),
        .pendiente (pendiente),
        .trama_fin (trama_fin)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Frame position k: slot k/6, lit for k%6 < 4, then 2 blank cycles.
    function automatic logic [3:0] exp_an(input logic [15:0] w, input logic s, input int k);
        int slot;
        logic [15:0] hi;
        slot = k / 6;
        hi   = w >> (4 * slot);
        if ((k % 6) >= 4) return 4'b0000;
        if (s && slot > 0 && hi == 16'h0) return 4'b0000;
        return 4'b0001 << slot;
    endfunction

    function automatic logic [3:0] exp_cd(input logic [15:0] w, input int k);
        logic [15:0] hi;
        hi = w >> (4 * (k / 6));
        return hi[3:0];
    endfunction

    // Records one 24-cycle frame, issuing up to two loads and setting supr_ceros for the next frame.
    task automatic run_frame(input int l1k, input logic [15:0] l1w,
                             input int l2k, input logic [15:0] l2w, input logic sn);
        for (int k = 0; k < 24; k++) begin
            an_obs[k] = anodos;
            cd_obs[k] = codigo;
            tf_obs[k] = trama_fin;
            pd_obs[k] = pendiente;
            cargar = 1'b0;
            if (k == l1k) begin cargar = 1'b1; datos = l1w; end
            if (k == l2k) begin cargar = 1'b1; datos = l2w; end
            if (k == 23) supr_ceros = sn;
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; habilitar = 1'b0; cargar = 1'b0; datos = 16'h0; supr_ceros = 1'b0;
        #3;
        total++;
        if ({anodos, codigo, pendiente, trama_fin} !== 10'b0) begin
            bad++;
            $display("FAIL reset_outputs got an=%b cd=%h pd=%b tf=%b want all 0", anodos, codigo, pendiente, trama_fin);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (anodos !== 4'b0000) begin
            bad++;
            $display("FAIL idle_dark got an=%b want 0000", anodos);
        end
        $display("[tb] test_reset finished");
    endtask

    task automatic test_scan;
        cargar = 1'b1; datos = 16'h4321;
        tick();
        cargar = 1'b0;
        total++;
        if (pendiente !== 1'b1 || anodos !== 4'b0000) begin
            bad++;
            $display("FAIL load_pending got pd=%b an=%b want pd=1 an=0000", pendiente, anodos);
        end
        habilitar = 1'b1;
        tick();
        // first frame entered from IDLE: no trama_fin at k=0
        run_frame(-1, 16'h0, -1, 16'h0, 1'b0);
        for (int k = 0; k < 24; k++) begin
            total++;
            if ({an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k]} !== {exp_an(16'h4321, 1'b0, k), exp_cd(16'h4321, k), 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL scan_f1 k=%0d got an=%b cd=%h tf=%b pd=%b want an=%b cd=%h tf=0 pd=0",
                         k, an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k], exp_an(16'h4321, 1'b0, k), exp_cd(16'h4321, k));
            end
        end
        // second frame: trama_fin at k=0, load 0007 at k=5, enable suppression for next frame
        run_frame(5, 16'h0007, -1, 16'h0, 1'b1);
        for (int k = 0; k < 24; k++) begin
            total++;
            if ({an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k]} !== {exp_an(16'h4321, 1'b0, k), exp_cd(16'h4321, k), k == 0, k > 5}) begin
                bad++;
                $display("FAIL scan_f2 k=%0d got an=%b cd=%h tf=%b pd=%b want an=%b cd=%h tf=%b pd=%b",
                         k, an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k], exp_an(16'h4321, 1'b0, k), exp_cd(16'h4321, k), k == 0, k > 5);
            end
        end
        $display("[tb] test_scan finished");
    endtask

    task automatic test_zero_suppress;
        run_frame(-1, 16'h0, -1, 16'h0, 1'b0);
        for (int k = 0; k < 24; k++) begin
            total++;
            if ({an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k]} !== {exp_an(16'h0007, 1'b1, k), exp_cd(16'h0007, k), k == 0, 1'b0}) begin
                bad++;
                $display("FAIL supp_on k=%0d got an=%b cd=%h tf=%b pd=%b want an=%b cd=%h tf=%b pd=0",
                         k, an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k], exp_an(16'h0007, 1'b1, k), exp_cd(16'h0007, k), k == 0);
            end
        end
        run_frame(20, 16'h1111, -1, 16'h0, 1'b0);
        for (int k = 0; k < 24; k++) begin
            total++;
            if ({an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k]} !== {exp_an(16'h0007, 1'b0, k), exp_cd(16'h0007, k), k == 0, k > 20}) begin
                bad++;
                $display("FAIL supp_off k=%0d got an=%b cd=%h tf=%b pd=%b want an=%b cd=%h tf=%b pd=%b",
                         k, an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k], exp_an(16'h0007, 1'b0, k), exp_cd(16'h0007, k), k == 0, k > 20);
            end
        end
        $display("[tb] test_zero_suppress finished");
    endtask

    task automatic test_last_load_wins;
        run_frame(4, 16'h3333, 14, 16'h2222, 1'b0);
        for (int k = 0; k < 24; k++) begin
            total++;
            if ({an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k]} !== {exp_an(16'h1111, 1'b0, k), exp_cd(16'h1111, k), k == 0, k > 4}) begin
                bad++;
                $display("FAIL ones_frame k=%0d got an=%b cd=%h tf=%b pd=%b want an=%b cd=%h tf=%b pd=%b",
                         k, an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k], exp_an(16'h1111, 1'b0, k), exp_cd(16'h1111, k), k == 0, k > 4);
            end
        end
        // load 5555 at k=23 so it is sampled on the commit edge
        run_frame(23, 16'h5555, -1, 16'h0, 1'b0);
        for (int k = 0; k < 24; k++) begin
            total++;
            if ({an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k]} !== {exp_an(16'h2222, 1'b0, k), exp_cd(16'h2222, k), k == 0, 1'b0}) begin
                bad++;
                $display("FAIL twos_frame k=%0d got an=%b cd=%h tf=%b pd=%b want an=%b cd=%h tf=%b pd=0",
                         k, an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k], exp_an(16'h2222, 1'b0, k), exp_cd(16'h2222, k), k == 0);
            end
        end
        $display("[tb] test_last_load_wins finished");
    endtask

    task automatic test_back_to_back;
        run_frame(-1, 16'h0, -1, 16'h0, 1'b0);
        for (int k = 0; k < 24; k++) begin
            total++;
            if ({an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k]} !== {exp_an(16'h5555, 1'b0, k), exp_cd(16'h5555, k), k == 0, 1'b0}) begin
                bad++;
                $display("FAIL edge_load k=%0d got an=%b cd=%h tf=%b pd=%b want an=%b cd=%h tf=%b pd=0",
                         k, an_obs[k], cd_obs[k], tf_obs[k], pd_obs[k], exp_an(16'h5555, 1'b0, k), exp_cd(16'h5555, k), k == 0);
            end
        end
        $display("[tb] test_back_to_back finished");
    endtask

    task automatic test_disable;
        for (int i = 0; i < 13; i++) tick();
        total++;
        if (anodos !== 4'b0100 || codigo !== 4'h5) begin
            bad++;
            $display("FAIL slot2_lit got an=%b cd=%h want an=0100 cd=5", anodos, codigo);
        end
        habilitar = 1'b0;
        tick();
        total++;
        if (anodos !== 4'b0000 || trama_fin !== 1'b0) begin
            bad++;
            $display("FAIL disable_dark got an=%b tf=%b want an=0000 tf=0", anodos, trama_fin);
        end
        cargar = 1'b1; datos = 16'h9999;
        tick();
        cargar = 1'b0;
        tick();
        total++;
        if (pendiente !== 1'b1 || anodos !== 4'b0000) begin
            bad++;
            $display("FAIL idle_pending got pd=%b an=%b want pd=1 an=0000", pendiente, anodos);
        end
        habilitar = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({anodos, codigo, trama_fin, pendiente} !== {(k < 4) ? 4'b0001 : 4'b0000, 4'h9, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reenable k=%0d got an=%b cd=%h tf=%b pd=%b want an=%b cd=9 tf=0 pd=0",
                         k, anodos, codigo, trama_fin, pendiente, (k < 4) ? 4'b0001 : 4'b0000);
            end
            if (k < 4) tick();
        end
        $display("[tb] test_disable finished");
    endtask

    task automatic test_async_reset;
        // currently 1ns into the first BLANK cycle of digit 0
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({anodos, codigo, pendiente, trama_fin} !== 10'b0) begin
            bad++;
            $display("FAIL async_reset got an=%b cd=%h pd=%b tf=%b want all 0", anodos, codigo, pendiente, trama_fin);
        end
        #2;
        rst_n = 1'b1;
        tick();
        total++;
        if (anodos !== 4'b0001 || codigo !== 4'h0 || pendiente !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got an=%b cd=%h pd=%b want an=0001 cd=0 pd=0", anodos, codigo, pendiente);
        end
        $display("[tb] test_async_reset finished");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_zero_suppress();
        test_last_load_wins();
        test_back_to_back();
        test_disable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
